// File: rtl/keypad_pkg.sv
// Shared keypad types and constants, also used by the display path.
package keypad_pkg;

  localparam int unsigned ROW_W = 4;
  localparam int unsigned COL_W = 4;
  localparam int unsigned KEY_W = 4;

  localparam logic [ROW_W-1:0] NO_ROW = 4'b1111;

  typedef enum logic [2:0] {
    SETTLE,
    WAIT,
    DEBOUNCE,
    PRESSED,
    HOLD
  } state_t;

  // Entry {row,col} occupies nibble row*4+col; rows: 123A / 456B / 789C / E0FD.
  localparam logic [63:0] KEYMAP_TABLE = 64'hDF0E_C987_B654_A321;

  function automatic logic [KEY_W-1:0] keymap(input logic [1:0] row_idx,
                                               input logic [1:0] col_idx);
    logic [5:0] base;
    base = 6'({row_idx, col_idx, 2'b00});
    return KEYMAP_TABLE[base +: 4];
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Scanner <-> synchronizer / display bundle.
interface keypad_scanner_if;
  import keypad_pkg::*;

  logic [ROW_W-1:0] synchrows;
  logic             synch_done;
  logic             WE_synch;
  logic [COL_W-1:0] cols;
  logic [KEY_W-1:0] key;
  logic             key_valid;

  modport master (
    input  synchrows, synch_done,
    output WE_synch, cols, key, key_valid
  );

  modport slave (
    output synchrows, synch_done,
    input  WE_synch, cols, key, key_valid
  );
endinterface

// File: rtl/keypad_scanner_stable_counter.sv
// Counts consecutive cycles where pattern equals reference; flags the terminal cycle.
module stable_counter
  import keypad_pkg::*;
#(
  parameter int unsigned LIMIT = 20000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [ROW_W-1:0] pattern,
  input  logic [ROW_W-1:0] reference,
  output logic             match_c,
  output logic             term_c
);
  localparam int unsigned CNT_W = $clog2(LIMIT);

  logic [CNT_W-1:0] cnt;

  assign match_c = (pattern == reference);
  assign term_c  = match_c && (cnt == CNT_W'(LIMIT - 1));

  // A mismatch or the terminal cycle both restart the run, so cnt never wraps.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= (match_c && !term_c) ? cnt + 1'b1 : '0;
    end
  end
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with press/release debounce and one key pulse per press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
  input  logic              clk,
  input  logic              reset,
  keypad_scanner_if.master  bus
);
  state_t           state_q, state_d;
  logic [1:0]       col_q, col_d;
  logic [ROW_W-1:0] row_lat_q, row_lat_d;
  logic [COL_W-1:0] cols_q;
  logic [KEY_W-1:0] key_q, key_d;
  logic             key_valid_q, key_valid_d;
  logic             we_q, we_d;
  logic [1:0]       row_idx;
  logic             cnt_clear, cnt_enable;
  logic [ROW_W-1:0] cnt_ref;
  logic             match_c, term_c;

  stable_counter #(.LIMIT(DEBOUNCE_CYCLES)) u_stable (
    .clk       (clk),
    .reset     (reset),
    .clear     (cnt_clear),
    .enable    (cnt_enable),
    .pattern   (bus.synchrows),
    .reference (cnt_ref),
    .match_c   (match_c),
    .term_c    (term_c)
  );

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_lat_d   = row_lat_q;
    key_d       = key_q;
    key_valid_d = 1'b0;
    row_idx     = '0;
    cnt_enable  = (state_q == DEBOUNCE) || (state_q == HOLD);
    cnt_clear   = !cnt_enable;
    cnt_ref     = (state_q == HOLD) ? NO_ROW : row_lat_q;

    // Lowest-index low row wins.
    for (int i = ROW_W - 1; i >= 0; i--) begin
      if (!row_lat_q[i]) row_idx = 2'(i);
    end

    unique case (state_q)
      SETTLE: state_d = WAIT;
      WAIT: begin
        if (bus.synch_done) begin
          if (bus.synchrows == NO_ROW) begin
            col_d   = col_q + 2'd1;
            state_d = SETTLE;
          end else begin
            row_lat_d = bus.synchrows;
            state_d   = DEBOUNCE;
          end
        end
      end
      DEBOUNCE: begin
        if (match_c) begin
          if (term_c) state_d = PRESSED;
        end else if (bus.synchrows == NO_ROW) begin
          col_d   = col_q + 2'd1;
          state_d = SETTLE;
        end else begin
          row_lat_d = bus.synchrows;
        end
      end
      PRESSED: state_d = HOLD;
      HOLD: begin
        if (term_c) begin
          col_d   = col_q + 2'd1;
          state_d = SETTLE;
        end
      end
      default: state_d = SETTLE;
    endcase

    we_d = (state_d != SETTLE);
    if (state_d == PRESSED) begin
      key_valid_d = 1'b1;
      key_d       = keymap(row_idx, col_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SETTLE;
      col_q       <= '0;
      row_lat_q   <= NO_ROW;
      cols_q      <= 4'b1110;
      we_q        <= 1'b0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_lat_q   <= row_lat_d;
      cols_q      <= ~(COL_W'(1) << col_d);
      we_q        <= we_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign bus.cols      = cols_q;
  assign bus.WE_synch  = we_q;
  assign bus.key       = key_q;
  assign bus.key_valid = key_valid_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized + directed bench for keypad_scanner against a behavioural scan/debounce model.
module tb_keypad_scanner;
  localparam int unsigned DC = 8;
  localparam int PH_SETTLE = 0, PH_SCAN = 1, PH_DEB = 2, PH_PRESS = 3, PH_HOLD = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  keypad_scanner_if bus();
  keypad_scanner #(.DEBOUNCE_CYCLES(DC)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int failures = 0;
  int pulses = 0;
  int kv_edge = 0;
  int edge_no = 0;
  int deb_edge = 0;
  logic [3:0] last_key = 4'h0;

  logic [3:0] press [4];
  logic [1:0] scnt;
  logic [3:0] srows;
  logic [3:0] key_tab [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                               4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
  logic [3:0] sweep [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

  function automatic int drv_col(input logic [3:0] c);
    for (int i = 0; i < 4; i++) if (c[i] === 1'b0) return i;
    return 0;
  endfunction

  function automatic int low_row(input logic [3:0] r);
    for (int i = 0; i < 4; i++) if (!r[i]) return i;
    return 0;
  endfunction

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // Synchronizer stand-in: one register stage on rows, done after 3 enabled cycles.
  always @(posedge clk) begin
    if (reset || !bus.WE_synch) scnt <= 2'd0;
    else if (scnt != 2'd2) scnt <= scnt + 2'd1;
    srows <= reset ? 4'hF : press[drv_col(bus.cols)];
  end
  assign bus.synch_done = (scnt == 2'd2);
  assign bus.synchrows  = srows;

  // Reference model: scan until a row shows, count a run of identical samples, then wait out a release run.
  int m_ph, m_col, m_run;
  logic [3:0] m_lat;
  bit started = 0;
  logic [3:0] e_cols, e_key;
  logic e_we, e_kv;

  always @(posedge clk) begin
    bit adv, kv;
    edge_no++;
    if (reset) begin
      started = 1;
      m_ph = PH_SETTLE; m_col = 0; m_run = 0; m_lat = 4'hF;
      e_cols <= 4'b1110; e_we <= 1'b0; e_key <= 4'h0; e_kv <= 1'b0;
    end else begin
      adv = 0; kv = 0;
      case (m_ph)
        PH_SETTLE: m_ph = PH_SCAN;
        PH_SCAN: if (bus.synch_done) begin
          if (bus.synchrows == 4'hF) adv = 1;
          else begin m_lat = bus.synchrows; m_run = 0; m_ph = PH_DEB; deb_edge = edge_no; end
        end
        PH_DEB: begin
          if (bus.synchrows == m_lat) begin
            m_run++;
            if (m_run == DC) begin m_ph = PH_PRESS; kv = 1; end
          end else if (bus.synchrows == 4'hF) adv = 1;
          else begin m_lat = bus.synchrows; m_run = 0; end
        end
        PH_PRESS: begin m_ph = PH_HOLD; m_run = 0; end
        default: begin
          if (bus.synchrows == 4'hF) begin
            m_run++;
            if (m_run == DC) adv = 1;
          end else m_run = 0;
        end
      endcase
      if (adv) begin m_col = (m_col + 1) % 4; m_ph = PH_SETTLE; end
      if (kv) e_key <= key_tab[low_row(m_lat) * 4 + m_col];
      e_kv   <= kv;
      e_cols <= 4'hF ^ (4'd1 << m_col);
      e_we   <= (m_ph != PH_SETTLE);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("cols", bus.cols, e_cols);
      check("we_synch", {3'b0, bus.WE_synch}, {3'b0, e_we});
      check("key", bus.key, e_key);
      check("key_valid", {3'b0, bus.key_valid}, {3'b0, e_kv});
    end
    if (bus.key_valid === 1'b1) begin
      pulses++; last_key = bus.key; kv_edge = edge_no;
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic wait_pulse(input int bound, input int base, output bit ok);
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      cycles(1);
      if (pulses > base) begin ok = 1; break; end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int base, n;
    logic [3:0] pat;
    int c;
    for (int i = 0; i < 4; i++) press[i] = 4'hF;

    reset = 1'b1;
    cycles(2);
    check("rst_cols", bus.cols, 4'b1110);
    check("rst_we", {3'b0, bus.WE_synch}, 4'h0);
    check("rst_key", bus.key, 4'h0);
    check("rst_kv", {3'b0, bus.key_valid}, 4'h0);
    reset = 1'b0;

    for (int k = 1; k <= 16; k++) begin
      cycles(1);
      if (k % 4 == 0) check("sweep_cols", bus.cols, sweep[k / 4 - 1]);
    end
    check("sweep_no_pulse", 4'(pulses), 4'd0);

    // Clean press: row1 on col2.
    base = pulses;
    press[2] = 4'b1101;
    wait_pulse(100, base, ok);
    check("clean_seen", {3'b0, ok}, 4'h1);
    check("clean_key", last_key, 4'h6);
    check("clean_latency", 4'(kv_edge - deb_edge), 4'd8);
    for (int i = 0; i < 30; i++) begin
      cycles(1);
      if (i % 10 == 0) check("clean_hold_cols", bus.cols, 4'b1011);
    end
    press[2] = 4'hF;
    cycles(20);
    check("clean_one_pulse", 4'(pulses - base), 4'd1);

    // Bounce on row0/col3.
    base = pulses;
    for (int i = 0; i < 20; i++) begin
      press[3] = ((i / 3) % 2 == 0) ? 4'b1110 : 4'hF;
      cycles(1);
    end
    check("bounce_no_pulse", 4'(pulses - base), 4'd0);
    press[3] = 4'b1110;
    wait_pulse(100, base, ok);
    check("bounce_seen", {3'b0, ok}, 4'h1);
    check("bounce_key", last_key, 4'hA);
    press[3] = 4'hF;
    cycles(20);
    check("bounce_one_pulse", 4'(pulses - base), 4'd1);

    // Long hold of key 0 with a glitchy release.
    base = pulses;
    press[1] = 4'b0111;
    wait_pulse(100, base, ok);
    check("hold_seen", {3'b0, ok}, 4'h1);
    check("hold_key", last_key, 4'h0);
    cycles(200);
    check("hold_one_pulse", 4'(pulses - base), 4'd1);
    check("hold_cols", bus.cols, 4'b1101);
    press[1] = 4'hF;    cycles(3);
    press[1] = 4'b0111; cycles(1);
    press[1] = 4'hF;    cycles(3);
    press[1] = 4'b0111; cycles(1);
    press[1] = 4'hF;
    n = 0;
    while (bus.cols !== 4'b1011 && n < 50) begin cycles(1); n++; end
    check("release_cycles", 4'(n), 4'd9);
    check("release_one_pulse", 4'(pulses - base), 4'd1);

    // Two rows on col0: row0 wins.
    base = pulses;
    press[0] = 4'b1010;
    wait_pulse(100, base, ok);
    check("tworow_seen", {3'b0, ok}, 4'h1);
    check("tworow_key", last_key, 4'h1);
    press[0] = 4'hF;
    cycles(20);

    // Reset in the middle of a debounce run.
    base = pulses;
    press[2] = 4'b1101;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (m_ph == PH_DEB && m_run == 5) begin ok = 1; break; end
      cycles(1);
    end
    check("mid_deb_reached", {3'b0, ok}, 4'h1);
    reset = 1'b1;
    press[2] = 4'hF;
    cycles(1);
    check("midrst_cols", bus.cols, 4'b1110);
    check("midrst_we", {3'b0, bus.WE_synch}, 4'h0);
    check("midrst_key", bus.key, 4'h0);
    check("midrst_kv", {3'b0, bus.key_valid}, 4'h0);
    reset = 1'b0;
    cycles(4);
    check("midrst_restart", bus.cols, 4'b1101);
    check("midrst_no_pulse", 4'(pulses - base), 4'd0);

    // Randomized presses with bounce, checked cycle by cycle against the model.
    for (int it = 0; it < 25; it++) begin
      c = int'($urandom_range(0, 3));
      pat = 4'($urandom_range(0, 14));
      repeat ($urandom_range(0, 3)) begin
        press[c] = pat;  cycles(int'($urandom_range(1, 4)));
        press[c] = 4'hF; cycles(int'($urandom_range(1, 3)));
      end
      press[c] = pat;
      cycles(int'($urandom_range(5, 60)));
      press[c] = 4'hF;
      cycles(int'($urandom_range(5, 40)));
    end

    cycles(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
